// File: rtl/axi_stream_pkg.sv
// Types and helpers shared by the AXI-Stream header insert/extract stages.
package axi_stream_pkg;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_BODY = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    localparam int MAX_BYTES = 64;

    // Number of enabled byte lanes; callers zero-extend their keep to MAX_BYTES.
    function automatic int unsigned keep_count(input logic [MAX_BYTES-1:0] keep);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            cnt = cnt + {31'b0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axi_stream_byte_shift.sv
// MSB-aligned concatenation of a residue (res_cnt bytes) with a new beat (beat_cnt bytes).
// cat_* is the first full-or-final word, rem_* the beat bytes that spill past it.
module axi_stream_byte_shift #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic [DATA_WD-1:0]      res_data,
    input  logic [CNT_WD-1:0]       res_cnt,
    input  logic [DATA_WD-1:0]      beat_data,
    input  logic [CNT_WD-1:0]       beat_cnt,
    output logic [DATA_WD-1:0]      cat_data,
    output logic [DATA_BYTE_WD-1:0] cat_keep,
    output logic [DATA_WD-1:0]      rem_data,
    output logic [DATA_BYTE_WD-1:0] rem_keep,
    output logic [CNT_WD-1:0]       rem_cnt
);

    localparam int TOT_WD = CNT_WD + 1;
    localparam logic [TOT_WD-1:0] W_TOT = TOT_WD'(DATA_BYTE_WD);

    logic [TOT_WD-1:0] total;
    logic [CNT_WD-1:0] cat_cnt;
    logic [CNT_WD-1:0] free_cnt;

    function automatic logic [DATA_BYTE_WD-1:0] msb_keep(input logic [CNT_WD-1:0] cnt);
        return ~({DATA_BYTE_WD{1'b1}} >> cnt);
    endfunction

    function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] keep);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[i*8 +: 8] = {8{keep[i]}};
        end
        return m;
    endfunction

    assign total    = TOT_WD'(res_cnt) + TOT_WD'(beat_cnt);
    assign cat_cnt  = (total > W_TOT) ? CNT_WD'(DATA_BYTE_WD) : CNT_WD'(total);
    assign rem_cnt  = (total > W_TOT) ? CNT_WD'(total - W_TOT) : '0;
    assign free_cnt = CNT_WD'(DATA_BYTE_WD) - res_cnt;

    // Shifts by a full word width yield zero, so an empty residue needs no special case.
    assign cat_keep = msb_keep(cat_cnt);
    assign cat_data = (res_data | (beat_data >> {res_cnt, 3'b000})) & lane_mask(cat_keep);
    assign rem_keep = msb_keep(rem_cnt);
    assign rem_data = (beat_data << {free_cnt, 3'b000}) & lane_mask(rem_keep);

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips a 1..DATA_BYTE_WD byte header from the first beat of each packet onto a
// header channel and re-packs the remaining payload into full MSB-aligned beats.
//
// state  | meaning
// S_HDR  | waiting for the first beat of a packet (header beat)
// S_BODY | mid-packet; each beat completes one output word from residue + new bytes
// S_TAIL | last input beat overflowed; residue still owes one final output beat
module axi_stream_extract_header
    import axi_stream_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    input  logic [BYTE_CNT_WD-1:0]  byte_header_cnt,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    output logic                    valid_header,
    input  logic                    ready_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header
);

    localparam int CNT_WD = BYTE_CNT_WD + 1;
    localparam logic [CNT_WD-1:0] W_CNT = CNT_WD'(DATA_BYTE_WD);

    state_t state, state_nxt;

    logic [DATA_WD-1:0]      residue_q;
    logic [CNT_WD-1:0]       residue_cnt_q;

    logic [CNT_WD-1:0]       n_in;
    logic [CNT_WD-1:0]       h_cur;
    logic [CNT_WD-1:0]       hdr_cnt;
    logic [CNT_WD-1:0]       hdr_skip;
    logic                    slot_free;
    logic                    accept;

    logic [DATA_WD-1:0]      sh_res_data;
    logic [CNT_WD-1:0]       sh_res_cnt;
    logic [DATA_WD-1:0]      sh_beat_data;
    logic [CNT_WD-1:0]       sh_beat_cnt;
    logic [DATA_WD-1:0]      cat_data;
    logic [DATA_BYTE_WD-1:0] cat_keep;
    logic [DATA_WD-1:0]      rem_data;
    logic [DATA_BYTE_WD-1:0] rem_keep;
    logic [CNT_WD-1:0]       rem_cnt;

    logic                    out_load;
    logic [DATA_WD-1:0]      out_data_nxt;
    logic [DATA_BYTE_WD-1:0] out_keep_nxt;
    logic                    out_last_nxt;
    logic                    hdr_load;
    logic                    res_load;

    assign n_in      = CNT_WD'(keep_count(MAX_BYTES'(keep_in)));
    assign h_cur     = CNT_WD'(byte_header_cnt) + CNT_WD'(1);
    assign hdr_cnt   = (n_in < h_cur) ? n_in : h_cur;
    assign hdr_skip  = W_CNT - hdr_cnt;
    assign slot_free = !valid_out || ready_out;

    assign ready_in = (state == S_HDR)  ? (!valid_header && slot_free) :
                      (state == S_BODY) ? slot_free : 1'b0;
    assign accept   = valid_in && ready_in;

    // In S_HDR the shifter sees an empty (zero) residue of W-H bytes, which makes
    // rem_* the post-header bytes; in S_TAIL it sees an empty beat.
    assign sh_res_data  = (state == S_HDR) ? '0 : residue_q;
    assign sh_res_cnt   = (state == S_HDR) ? (W_CNT - h_cur) : residue_cnt_q;
    assign sh_beat_data = (state == S_TAIL) ? '0 : data_in;
    assign sh_beat_cnt  = (state == S_TAIL) ? '0 : n_in;

    axi_stream_byte_shift #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .CNT_WD       (CNT_WD)
    ) u_shift (
        .res_data  (sh_res_data),
        .res_cnt   (sh_res_cnt),
        .beat_data (sh_beat_data),
        .beat_cnt  (sh_beat_cnt),
        .cat_data  (cat_data),
        .cat_keep  (cat_keep),
        .rem_data  (rem_data),
        .rem_keep  (rem_keep),
        .rem_cnt   (rem_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        out_load     = 1'b0;
        out_data_nxt = cat_data;
        out_keep_nxt = cat_keep;
        out_last_nxt = 1'b0;
        hdr_load     = 1'b0;
        res_load     = 1'b0;
        case (state)
            S_HDR: begin
                if (accept) begin
                    hdr_load = 1'b1;
                    res_load = 1'b1;
                    if (!last_in) begin
                        state_nxt = S_BODY;
                    end else if (rem_cnt != '0) begin
                        out_load     = 1'b1;
                        out_data_nxt = rem_data;
                        out_keep_nxt = rem_keep;
                        out_last_nxt = 1'b1;
                    end
                end
            end
            S_BODY: begin
                if (accept) begin
                    out_load = 1'b1;
                    res_load = 1'b1;
                    if (last_in) begin
                        if (rem_cnt != '0) begin
                            state_nxt = S_TAIL;
                        end else begin
                            out_last_nxt = 1'b1;
                            state_nxt    = S_HDR;
                        end
                    end
                end
            end
            S_TAIL: begin
                if (slot_free) begin
                    out_load     = 1'b1;
                    out_last_nxt = 1'b1;
                    state_nxt    = S_HDR;
                end
            end
            default: state_nxt = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            residue_q     <= '0;
            residue_cnt_q <= '0;
            valid_out     <= 1'b0;
            data_out      <= '0;
            keep_out      <= '0;
            last_out      <= 1'b0;
            valid_header  <= 1'b0;
            data_header   <= '0;
            keep_header   <= '0;
        end else begin
            if (res_load) begin
                residue_q     <= rem_data;
                residue_cnt_q <= rem_cnt;
            end
            if (out_load) begin
                valid_out <= 1'b1;
                data_out  <= out_data_nxt;
                keep_out  <= out_keep_nxt;
                last_out  <= out_last_nxt;
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
            if (hdr_load) begin
                valid_header <= 1'b1;
                data_header  <= data_in >> {hdr_skip, 3'b000};
                keep_header  <= ~({DATA_BYTE_WD{1'b1}} << hdr_cnt);
            end else if (ready_header) begin
                valid_header <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed bench for axi_stream_extract_header with hand-computed expected beats.
module tb_axi_stream_extract_header;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic [1:0]  byte_header_cnt;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        valid_header;
    logic        ready_header;
    logic [31:0] data_header;
    logic [3:0]  keep_header;

    int n_checks = 0;
    int n_pass   = 0;

    logic [36:0] pay_q[$];
    logic [35:0] hdr_q[$];

    axi_stream_extract_header #(
        .DATA_WD      (32),
        .DATA_BYTE_WD (4),
        .BYTE_CNT_WD  (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_in        (valid_in),
        .ready_in        (ready_in),
        .data_in         (data_in),
        .keep_in         (keep_in),
        .last_in         (last_in),
        .byte_header_cnt (byte_header_cnt),
        .valid_out       (valid_out),
        .ready_out       (ready_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .last_out        (last_out),
        .valid_header    (valid_header),
        .ready_header    (ready_header),
        .data_header     (data_header),
        .keep_header     (keep_header)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes complete at the next posedge; inputs are stable by the negedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_out && ready_out) pay_q.push_back({data_out, keep_out, last_out});
            if (valid_header && ready_header) hdr_q.push_back({data_header, keep_header});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish, required finish before 300000");
        $fatal(1);
    end

    task automatic sync_edge();
        @(posedge clk);
        #1;
    endtask

    // Must be called just after a posedge; returns just after the accepting posedge.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic [1:0] cnt);
        int t;
        t = 0;
        valid_in = 1'b1;
        data_in = d;
        keep_in = k;
        last_in = l;
        byte_header_cnt = cnt;
        @(negedge clk);
        while (!ready_in && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready_in) begin
            n_checks++;
            $display("FAIL send_timeout data=%h ready_in=%b required 1", d, ready_in);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_drain(input int np, input int nh);
        int t;
        t = 0;
        while ((pay_q.size() < np || hdr_q.size() < nh) && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_in = 1'b0;
        data_in = '0;
        keep_in = '0;
        last_in = 1'b0;
        byte_header_cnt = '0;
        ready_out = 1'b1;
        ready_header = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b0 || valid_header !== 1'b0)
            $display("FAIL reset_valid got valid_out=%b valid_header=%b required 0/0", valid_out, valid_header);
        else n_pass++;
        n_checks++;
        if ({data_out, keep_out, last_out} !== 37'h0)
            $display("FAIL reset_payload got data=%h keep=%h last=%b required zero", data_out, keep_out, last_out);
        else n_pass++;
        n_checks++;
        if ({data_header, keep_header} !== 36'h0)
            $display("FAIL reset_header got data=%h keep=%h required zero", data_header, keep_header);
        else n_pass++;
        n_checks++;
        if (ready_in !== 1'b1)
            $display("FAIL reset_ready_in got %b required 1", ready_in);
        else n_pass++;
    endtask

    task automatic test_h1();
        logic [36:0] exp_p [3] = '{{32'hBBCCDD11, 4'hF, 1'b0}, {32'h22334455, 4'hF, 1'b0},
                                   {32'h66000000, 4'h8, 1'b1}};
        logic [36:0] got;
        pay_q.delete();
        hdr_q.delete();
        sync_edge();
        send_beat(32'hAABBCCDD, 4'hF, 1'b0, 2'd0);
        send_beat(32'h11223344, 4'hF, 1'b0, 2'd0);
        send_beat(32'h55667788, 4'hC, 1'b1, 2'd0);
        wait_drain(3, 1);
        n_checks++;
        if (pay_q.size() != 3 || hdr_q.size() != 1)
            $display("FAIL h1_count got payload=%0d header=%0d required 3/1", pay_q.size(), hdr_q.size());
        else n_pass++;
        n_checks++;
        if (hdr_q.size() < 1 || hdr_q[0] !== {32'h000000AA, 4'h1})
            $display("FAIL h1_header got %h required %h", (hdr_q.size() > 0) ? hdr_q[0] : 36'h0, {32'h000000AA, 4'h1});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            got = (i < pay_q.size()) ? pay_q[i] : 37'h0;
            n_checks++;
            if (got !== exp_p[i])
                $display("FAIL h1_payload[%0d] got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                         i, got[36:5], got[4:1], got[0], exp_p[i][36:5], exp_p[i][4:1], exp_p[i][0]);
            else n_pass++;
        end
    endtask

    task automatic test_h2_two_beat();
        logic [36:0] got;
        pay_q.delete();
        hdr_q.delete();
        sync_edge();
        send_beat(32'h01020304, 4'hF, 1'b0, 2'd1);
        send_beat(32'h05060000, 4'hC, 1'b1, 2'd1);
        wait_drain(1, 1);
        n_checks++;
        if (pay_q.size() != 1 || hdr_q.size() != 1)
            $display("FAIL h2_count got payload=%0d header=%0d required 1/1", pay_q.size(), hdr_q.size());
        else n_pass++;
        n_checks++;
        if (hdr_q.size() < 1 || hdr_q[0] !== {32'h00000102, 4'h3})
            $display("FAIL h2_header got %h required %h", (hdr_q.size() > 0) ? hdr_q[0] : 36'h0, {32'h00000102, 4'h3});
        else n_pass++;
        got = (pay_q.size() > 0) ? pay_q[0] : 37'h0;
        n_checks++;
        if (got !== {32'h03040506, 4'hF, 1'b1})
            $display("FAIL h2_payload got data=%h keep=%h last=%b required data=03040506 keep=f last=1",
                     got[36:5], got[4:1], got[0]);
        else n_pass++;
    endtask

    task automatic test_h2_single();
        logic [36:0] got;
        pay_q.delete();
        hdr_q.delete();
        sync_edge();
        send_beat(32'hDEADBEEF, 4'hE, 1'b1, 2'd1);
        send_beat(32'hDEADBEEF, 4'hC, 1'b1, 2'd1);
        wait_drain(1, 2);
        n_checks++;
        if (pay_q.size() != 1 || hdr_q.size() != 2)
            $display("FAIL single_count got payload=%0d header=%0d required 1/2", pay_q.size(), hdr_q.size());
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (hdr_q.size() <= i || hdr_q[i] !== {32'h0000DEAD, 4'h3})
                $display("FAIL single_header[%0d] got %h required %h", i,
                         (hdr_q.size() > i) ? hdr_q[i] : 36'h0, {32'h0000DEAD, 4'h3});
            else n_pass++;
        end
        got = (pay_q.size() > 0) ? pay_q[0] : 37'h0;
        n_checks++;
        if (got !== {32'hBE000000, 4'h8, 1'b1})
            $display("FAIL single_payload got data=%h keep=%h last=%b required data=be000000 keep=8 last=1",
                     got[36:5], got[4:1], got[0]);
        else n_pass++;
    endtask

    task automatic test_h4_passthrough();
        logic [36:0] exp_p [2] = '{{32'h0F1E2D3C, 4'hF, 1'b0}, {32'h55AA33CC, 4'hF, 1'b1}};
        logic [36:0] got;
        pay_q.delete();
        hdr_q.delete();
        sync_edge();
        send_beat(32'hA1B2C3D4, 4'hF, 1'b0, 2'd3);
        send_beat(32'h0F1E2D3C, 4'hF, 1'b0, 2'd3);
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== 32'h0F1E2D3C || keep_out !== 4'hF)
            $display("FAIL h4_latency got valid=%b data=%h keep=%h required 1/0f1e2d3c/f", valid_out, data_out, keep_out);
        else n_pass++;
        send_beat(32'h55AA33CC, 4'hF, 1'b1, 2'd3);
        wait_drain(2, 1);
        n_checks++;
        if (pay_q.size() != 2 || hdr_q.size() != 1)
            $display("FAIL h4_count got payload=%0d header=%0d required 2/1", pay_q.size(), hdr_q.size());
        else n_pass++;
        n_checks++;
        if (hdr_q.size() < 1 || hdr_q[0] !== {32'hA1B2C3D4, 4'hF})
            $display("FAIL h4_header got %h required %h", (hdr_q.size() > 0) ? hdr_q[0] : 36'h0, {32'hA1B2C3D4, 4'hF});
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            got = (i < pay_q.size()) ? pay_q[i] : 37'h0;
            n_checks++;
            if (got !== exp_p[i])
                $display("FAIL h4_payload[%0d] got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                         i, got[36:5], got[4:1], got[0], exp_p[i][36:5], exp_p[i][4:1], exp_p[i][0]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [36:0] exp_p [3] = '{{32'h40506070, 4'hF, 1'b0}, {32'h8090A0B0, 4'hF, 1'b1},
                                   {32'hFEF00D12, 4'hF, 1'b1}};
        logic [35:0] exp_h [2] = '{{32'h00102030, 4'h7}, {32'h000000CA, 4'h1}};
        logic [36:0] got;
        logic [35:0] got_h;
        pay_q.delete();
        hdr_q.delete();
        sync_edge();
        ready_header = 1'b0;
        fork
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    ready_out = 1'($urandom_range(0, 1));
                end
                ready_out = 1'b1;
            end
            begin
                // Packet A: H=3; body beats carry a different byte_header_cnt that must be ignored.
                send_beat(32'h10203040, 4'hF, 1'b0, 2'd2);
                send_beat(32'h50607080, 4'hF, 1'b0, 2'd0);
                send_beat(32'h90A0B0C0, 4'hE, 1'b1, 2'd1);
                fork
                    begin
                        sync_edge();
                        send_beat(32'hCAFEF00D, 4'hF, 1'b0, 2'd0);
                        send_beat(32'h12345678, 4'h8, 1'b1, 2'd3);
                    end
                    begin
                        repeat (5) begin
                            @(negedge clk);
                            n_checks++;
                            if (ready_in !== 1'b0)
                                $display("FAIL bp_stall got ready_in=%b required 0 while header pending", ready_in);
                            else n_pass++;
                        end
                        ready_header = 1'b1;
                    end
                join
            end
        join
        wait_drain(3, 2);
        n_checks++;
        if (pay_q.size() != 3 || hdr_q.size() != 2)
            $display("FAIL bp_count got payload=%0d header=%0d required 3/2", pay_q.size(), hdr_q.size());
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            got_h = (i < hdr_q.size()) ? hdr_q[i] : 36'h0;
            n_checks++;
            if (got_h !== exp_h[i])
                $display("FAIL bp_header[%0d] got %h required %h", i, got_h, exp_h[i]);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < pay_q.size()) ? pay_q[i] : 37'h0;
            n_checks++;
            if (got !== exp_p[i])
                $display("FAIL bp_payload[%0d] got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                         i, got[36:5], got[4:1], got[0], exp_p[i][36:5], exp_p[i][4:1], exp_p[i][0]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [36:0] got;
        pay_q.delete();
        hdr_q.delete();
        sync_edge();
        ready_out = 1'b0;
        ready_header = 1'b0;
        send_beat(32'hAABBCCDD, 4'hF, 1'b0, 2'd0);
        send_beat(32'h11223344, 4'hF, 1'b0, 2'd0);
        n_checks++;
        if (valid_out !== 1'b1 || valid_header !== 1'b1)
            $display("FAIL rst_pre got valid_out=%b valid_header=%b required 1/1", valid_out, valid_header);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid_out, data_out, keep_out, last_out} !== 38'h0 ||
            {valid_header, data_header, keep_header} !== 37'h0)
            $display("FAIL rst_mid_outputs got vo=%b d=%h k=%h l=%b vh=%b dh=%h kh=%h required all zero",
                     valid_out, data_out, keep_out, last_out, valid_header, data_header, keep_header);
        else n_pass++;
        n_checks++;
        if (ready_in !== 1'b1)
            $display("FAIL rst_mid_ready_in got %b required 1", ready_in);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        ready_out = 1'b1;
        ready_header = 1'b1;
        pay_q.delete();
        hdr_q.delete();
        sync_edge();
        send_beat(32'h01020304, 4'hF, 1'b1, 2'd1);
        wait_drain(1, 1);
        n_checks++;
        if (pay_q.size() != 1 || hdr_q.size() != 1)
            $display("FAIL rst_after_count got payload=%0d header=%0d required 1/1", pay_q.size(), hdr_q.size());
        else n_pass++;
        n_checks++;
        if (hdr_q.size() < 1 || hdr_q[0] !== {32'h00000102, 4'h3})
            $display("FAIL rst_after_header got %h required %h", (hdr_q.size() > 0) ? hdr_q[0] : 36'h0,
                     {32'h00000102, 4'h3});
        else n_pass++;
        got = (pay_q.size() > 0) ? pay_q[0] : 37'h0;
        n_checks++;
        if (got !== {32'h03040000, 4'hC, 1'b1})
            $display("FAIL rst_after_payload got data=%h keep=%h last=%b required data=03040000 keep=c last=1",
                     got[36:5], got[4:1], got[0]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_h1();
        test_h2_two_beat();
        test_h2_single();
        test_h4_passthrough();
        test_backpressure();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_stream_extract_header.md
# axi_stream_extract_header

Downstream companion of the header-insert stage: consumes an AXI-Stream packet whose leading bytes are a header, strips a configurable number of header bytes (1..DATA_BYTE_WD) from the first beat, and delivers them on a separate header channel. The remaining payload is re-packed into full, MSB-aligned beats on the output stream. One header beat is produced per packet. The payload output is fully registered.

## Interface
- DATA_WD, 32, data width in bits (multiple of 8)
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of header byte count
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- valid_in / ready_in  in / out  1 / 1  input stream handshake
- data_in  in  DATA_WD  input data; byte lane DATA_BYTE_WD-1 (MSB) is first in stream order
- keep_in  in  DATA_BYTE_WD  byte enables, contiguous from MSB; only the last beat may be partial
- last_in  in  1  last beat of packet
- byte_header_cnt  in  BYTE_CNT_WD  header length minus one (H = cnt+1 bytes); sampled when the first beat is accepted
- valid_out / ready_out  out / in  1 / 1  payload handshake
- data_out, keep_out, last_out  out  DATA_WD, DATA_BYTE_WD, 1  payload beat; invalid byte lanes are driven zero
- valid_header / ready_header  out / in  1 / 1  header handshake
- data_header, keep_header  out  DATA_WD, DATA_BYTE_WD  header, right-aligned (LSB lanes), keep_header low bits set

## Operation
- W = DATA_BYTE_WD; n = number of set bits in keep_in; residue register holds up to W bytes plus a byte count.
- S_HDR: ready_in = !valid_header && (!valid_out || ready_out). On accept, latch H. Header = top min(n,H) bytes, right-aligned, valid_header=1. Residue = low W-H bytes.
  - if last_in && n>H: emit payload n-H bytes, last_out=1; stay in S_HDR.
  - if last_in && n<=H: no payload beat; stay in S_HDR.
  - else go to S_BODY.
- S_BODY: ready_in = !valid_out || ready_out. On accept: out = {residue, top min(n,H) bytes}.
  - !last_in: keep all ones, residue = low W-H bytes; stay.
  - last_in && n<=H: keep = (W-H)+n bytes from MSB, last_out=1; go to S_HDR.
  - last_in && n>H: keep all ones, last_out=0, residue = the n-H bytes after the first H; go to S_TAIL.
- S_TAIL: ready_in=0. When the output slot is free, emit residue MSB-aligned with keep of n-H bytes and last_out=1; go to S_HDR.
- H=W: residue is empty, so the block is a one-cycle pass-through of the payload. Shift logic must handle zero-byte residue without zero-width slices.
- The header register clears on valid_header && ready_header. A new packet cannot start until the previous header is taken.
- byte_header_cnt changes mid-packet are ignored.

## Timing
- Reset: valid_out=0, data_out=0, keep_out=0, last_out=0, valid_header=0, data_header=0, keep_header=0, state=S_HDR, residue cleared. ready_in=1 after reset (combinational).
- Latency: a payload beat appears the cycle after the input beat that completes it is accepted. A tail beat appears the cycle after the S_TAIL slot frees.
- Throughput: one beat per cycle in S_BODY with ready_out=1. A packet with a tail costs one extra cycle.
- valid_out/valid_header, once asserted, hold with stable data until the corresponding ready handshake completes.
- ready_in depends combinationally on ready_out and state, not on valid_in.
- Asynchronous reset mid-packet aborts the packet: the residue and header are discarded and the next accepted beat is treated as a first beat.

## Structure
- Shared package axi_stream_pkg: state enum (S_HDR, S_BODY, S_TAIL) and a keep-to-count function, both shared with the insert-header stage.
- One sub-module, axi_stream_byte_shift: combinational MSB-aligned concat/shift of residue and new beat by a byte count, producing data and keep.

## Test plan
- H=1 (cnt=0), beats 0xAABBCCDD/f, 0x11223344/f, 0x55667788/keep C last:
  - header 0x000000AA/0x1
  - payload 0xBBCCDD11/f, 0x22334455/f, 0x66000000/0x8 last
- H=2, beats 0x01020304/f, 0x05060000/keep C last: header 0x00000102/0x3; payload single beat 0x03040506/f last.
- H=2, single beat 0xDEADBEEF/keep E last: header 0x0000DEAD/0x3; payload 0xBE000000/0x8 last. Same with keep C: header only, no payload beat.
- H=4, three full beats with the last asserted: header equals beat0; payload equals beats 1 and 2 unchanged, one-cycle latency, last on beat 2.
- Backpressure: random ready_out toggling; ready_header held low for 5 cycles; second packet's first beat stalls (ready_in=0) until the header is taken; no beat lost or duplicated.
- Assert rst_n mid-packet in S_BODY: all outputs read 0 in the same cycle; the next packet is processed correctly from its first beat.
